md_stall_ctrl: RTL

- Schedules the shared multiply/divide unit and its HI/LO registers for the 5-stage MIPS pipeline.
- Computes mult/multu/div/divu over a fixed multi-cycle busy window.
- Holds IF/ID and PC (write-enable low) and bubbles ID/EX while a decode-stage HI/LO-using instruction must wait.
- Merges the external data-hazard stall into the single stall decision driving the IF/ID register.

---
 rtl/md_stall_if.sv | 28 ++
 rtl/md_stall_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/md_stall_if.sv
// Pipeline-side bundle for the multiply/divide stall controller.
// The pipeline drives the master side; md_stall_ctrl takes the slave side.
interface md_stall_if;
  logic        D_md_use;
  logic        stall_data;
  logic        E_start;
  logic [1:0]  E_op;
  logic        E_mthi;
  logic        E_mtlo;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        F_WE;
  logic        D_WE;
  logic        E_clr;

  modport master (
    output D_md_use, stall_data, E_start, E_op, E_mthi, E_mtlo, E_A, E_B,
    input  HI, LO, busy, F_WE, D_WE, E_clr
  );

  modport slave (
    input  D_md_use, stall_data, E_start, E_op, E_mthi, E_mtlo, E_A, E_B,
    output HI, LO, busy, F_WE, D_WE, E_clr
  );
endinterface

// File: rtl/md_stall_ctrl.sv
// Multiply/divide scheduler with HI/LO registers and the merged IF/ID stall.
// Optional MD_PERF_CNT_EN adds md_stall_cnt counting cycles stalled only by the MD unit.
module md_stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  md_stall_if.slave   md
`ifdef MD_PERF_CNT_EN
  ,
  output logic [31:0] md_stall_cnt
`endif
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int unsigned DW         = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [DW-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [DW-1:0]     pend_hi, pend_hi_d, pend_lo, pend_lo_d;
  logic [DW-1:0]     res_hi, res_lo;
  logic [2*DW-1:0]   prod;
  logic              is_div;
  logic              busy_c, stall_md_c, stall_c;

  assign is_div = md.E_op[1];

  // Result datapath: evaluated in the start cycle, held in pend_* until commit.
  always_comb begin
    prod   = '0;
    res_hi = '0;
    res_lo = '0;
    case (md.E_op)
      2'd0: begin
        prod   = {{DW{md.E_A[DW-1]}}, md.E_A} * {{DW{md.E_B[DW-1]}}, md.E_B};
        res_hi = prod[2*DW-1:DW];
        res_lo = prod[DW-1:0];
      end
      2'd1: begin
        prod   = {{DW{1'b0}}, md.E_A} * {{DW{1'b0}}, md.E_B};
        res_hi = prod[2*DW-1:DW];
        res_lo = prod[DW-1:0];
      end
      2'd2: begin
        if (md.E_B == '0) begin
          res_hi = md.E_A;
          res_lo = '1;
        end else if ((md.E_A == 32'h8000_0000) && (md.E_B == 32'hFFFF_FFFF)) begin
          // Quotient does not fit; return the dividend with zero remainder.
          res_hi = '0;
          res_lo = 32'h8000_0000;
        end else begin
          res_hi = $signed(md.E_A) % $signed(md.E_B);
          res_lo = $signed(md.E_A) / $signed(md.E_B);
        end
      end
      default: begin
        if (md.E_B == '0) begin
          res_hi = md.E_A;
          res_lo = '1;
        end else begin
          res_hi = md.E_A % md.E_B;
          res_lo = md.E_A / md.E_B;
        end
      end
    endcase
  end

  // Next-state logic: start, countdown, commit, and mthi/mtlo writes.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi;
    pend_lo_d = pend_lo;
    case (state)
      IDLE: begin
        if (md.E_start) begin
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          cnt_d     = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          state_d   = BUSY;
        end else begin
          if (md.E_mthi) hi_d = md.E_A;
          if (md.E_mtlo) lo_d = md.E_A;
        end
      end
      BUSY: begin
        if (cnt == CNT_W'(1)) begin
          hi_d    = pend_hi;
          lo_d    = pend_lo;
          state_d = IDLE;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_hi <= pend_hi_d;
      pend_lo <= pend_lo_d;
    end
  end

  // Stall merge: one stall decision, so data and MD hazards never double-bubble.
  assign busy_c     = md.E_start | (state == BUSY);
  assign stall_md_c = md.D_md_use & busy_c;
  assign stall_c    = stall_md_c | md.stall_data;

  assign md.busy  = busy_c;
  assign md.F_WE  = ~stall_c;
  assign md.D_WE  = ~stall_c;
  assign md.E_clr = stall_c;
  assign md.HI    = hi_q;
  assign md.LO    = lo_q;

`ifdef MD_PERF_CNT_EN
  // Counts cycles where the MD unit is the sole reason for the stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_stall_cnt <= '0;
    end else if (stall_md_c && !md.stall_data) begin
      md_stall_cnt <= md_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
